// File: rtl/robertsons_pkg.sv
// Shared types and defaults for the Robertson's multiplier sharing controller.
package robertsons_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } share_state_t;

    // Increment an index with wrap at n.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/robertsons_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter
    import robertsons_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] req_hi;
    logic [N_REQ-1:0] pick;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign hi_mask[gi] = (gi >= int'(rr_ptr));
        end
    endgenerate

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    assign req_hi = req & hi_mask;
    assign pick   = (|req_hi) ? req_hi : req;
    assign any    = |req;

    always_comb begin
        grant_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (int'(grant_id) == gi);
        end
    endgenerate

endmodule

// File: rtl/robertsons_share_ctrl.sv
// Time-shares one Robertson's signed multiplier among N_REQ requesters with
// round-robin arbitration, a completion watchdog and a valid/ready response port.
module robertsons_share_ctrl
    import robertsons_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_product,
    output logic                   rsp_err,
    output logic                   mult_start,
    output logic [WIDTH-1:0]       mult_multiplier,
    output logic [WIDTH-1:0]       mult_multiplicand,
    input  logic [2*WIDTH-1:0]     mult_product,
    input  logic                   mult_done,
    output logic                   busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    share_state_t         state_reg;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [ID_W-1:0]      id_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic                 start_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 valid_reg;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 err_reg;

    logic [N_REQ-1:0]     grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_reg),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    // Accept is offered only while idle, and never during reset.
    assign req_ready = (state_reg == IDLE && !reset) ? grant : '0;

    assign rsp_valid         = valid_reg;
    assign rsp_id            = id_reg;
    assign rsp_product       = product_reg;
    assign rsp_err           = err_reg;
    assign mult_start        = start_reg;
    assign mult_multiplier   = a_reg;
    assign mult_multiplicand = b_reg;
    assign busy              = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            id_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            start_reg   <= 1'b0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            product_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        id_reg    <= grant_id;
                        a_reg     <= req_a[grant_id*WIDTH +: WIDTH];
                        b_reg     <= req_b[grant_id*WIDTH +: WIDTH];
                        start_reg <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    start_reg <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // A count of zero marks the first WAIT cycle, where done may be stale.
                    if (cnt_reg != '0 && mult_done) begin
                        product_reg <= mult_product;
                        err_reg     <= 1'b0;
                        valid_reg   <= 1'b1;
                        state_reg   <= RESP;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        product_reg <= '0;
                        err_reg     <= 1'b1;
                        valid_reg   <= 1'b1;
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        valid_reg  <= 1'b0;
                        rr_ptr_reg <= ID_W'(next_index(int'(id_reg), N_REQ));
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/robertsons_share_ctrl.md
# robertsons_share_ctrl

Controller that time-shares one Robertson's signed multiplier (`toprobertsons`-style unit) among `N_REQ` requesters. It arbitrates round-robin and starts the multiplier by pulsing its start/reset input. It holds the operands stable, waits for `done` under a watchdog, and returns the product with the requester ID over a valid/ready response channel. It sits between the client ports and the single multiplier instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width; product is `2*WIDTH`
- `TIMEOUT`, 32, max cycles in WAIT before abort
- `clk` in 1: rising-edge clock
- `reset` in 1: reset, synchronous, active-high
- `req_valid` in `N_REQ`: request pending per requester
- `req_a` in `N_REQ`x`WIDTH`: signed multiplier operand per requester
- `req_b` in `N_REQ`x`WIDTH`: signed multiplicand operand per requester
- `req_ready` out `N_REQ`: one-hot accept; handshake = `req_valid[i] & req_ready[i]`
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts response
- `rsp_id` out `$clog2(N_REQ)`: index of the served requester
- `rsp_product` out `2*WIDTH`: signed product
- `rsp_err` out 1: watchdog expired; `rsp_product`=0
- `mult_start` out 1: drives multiplier reset/start, one-cycle pulse
- `mult_multiplier`, `mult_multiplicand` out `WIDTH`: operands to the multiplier
- `mult_product` in `2*WIDTH`, `mult_done` in 1: multiplier result and completion flag
- `busy` out 1: state != IDLE

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any `req_valid`, grant the first set bit at or after `rr_ptr` (wrap modulo `N_REQ`). Assert `req_ready[g]` combinationally in this cycle. Latch `req_a[g]`, `req_b[g]` and `g`. Go to START. No request: stay; `req_ready`=0.
- START: `mult_start`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT: the counter increments each cycle. `mult_done` is ignored on the first WAIT cycle, because done may be stale from the previous operation.
  - From the second WAIT cycle, `mult_done`=1 latches `mult_product`, clears err, and moves to RESP.
  - When the counter reaches `TIMEOUT` without done: product=0, err=1, go to RESP.
- RESP: `rsp_valid`=1; `rsp_id`, `rsp_product` and `rsp_err` are held stable until `rsp_ready`. On handshake, `rr_ptr` ← (g+1) mod `N_REQ`, then go to IDLE.
- `mult_multiplier`/`mult_multiplicand` show the latched operands from START through RESP. They are never changed mid-operation.
- Only one request is in flight. `req_ready` is 0 outside IDLE.
- Arithmetic is the multiplier's. The controller passes `2*WIDTH` bits unmodified (signed, two's complement).

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `rsp_err`=0, `mult_start`=0, operands=0, `busy`=0.
- Reset mid-operation: abort; no response is issued for the in-flight request. The system reset must also reset the multiplier.
- Latency: accept at cycle T, `mult_start` at T+1, WAIT from T+2. If done is sampled at cycle D, `rsp_valid` rises at D+1.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake.
- Simultaneous requests: only one is granted per IDLE visit. Losers keep `req_valid` high and must hold their operands.
- Requester dropping `req_valid` before grant: legal; it is simply not served.
- `rsp_ready` held 0: the FSM stays in RESP indefinitely and never accepts new requests.

## Structure
- Package `robertsons_pkg`:
  - state enum `share_state_t` {IDLE, START, WAIT, RESP}
  - default `WIDTH`, `N_REQ`, `TIMEOUT` localparams
- Sub-module `rr_arbiter`: purely combinational priority-rotate picker.
  - Inputs: `req` vector, `rr_ptr`.
  - Outputs: one-hot `grant`, binary `grant_id`, `any`.
- Top module: FSM, operand/ID/result registers, watchdog counter, `rr_ptr`.

## Test plan
- Single op: req0 (5, 6) with the real multiplier → one `req_ready[0]` pulse; `mult_start` one cycle later; `rsp_valid` with id=0, product=30, err=0.
- Contention: req0 (7, -5) and req2 (-5, 6) raised together → req0 served first (-35). After the RESP handshake, req2 is served (-30) with id=2.
- Rotation: all 4 requesting continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0.
- Extremes and backpressure: (-128, -128) → 16384 (0x4000). With `rsp_ready` low for 10 cycles, the outputs stay stable and no `req_ready` is asserted.
- Watchdog: stub multiplier with `mult_done` stuck 0 → `rsp_valid` with err=1, product=0 after `TIMEOUT` WAIT cycles. The stale-done case (done stuck 1) must not complete on the first WAIT cycle.
- Reset in WAIT: assert `reset` mid-op → next cycle all outputs are at reset values and `rr_ptr`=0. A new req1 (-9, -4) then yields 36.
